// File: rtl/gray_pix_packer.sv
// Float gray value -> 8-bit intensity, packed four pixels per 32-bit word with frame-end marking.
// Optional GRAY_PACK_ROUND_EN selects round-half-away-from-zero; default truncates toward zero.
module gray_pix_packer #(
  parameter int FRAME_PIXELS = 10000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [3:0]  out_keep,
  output logic        out_last
);

  localparam logic [19:0] LAST_IDX = 20'(FRAME_PIXELS - 1);

  function automatic logic [7:0] to_byte(input logic [31:0] f);
    logic       s;
    logic [7:0] e;
    logic [22:0] m;
    logic [23:0] mant;
    logic [7:0] sh;
    logic [7:0] q;
`ifdef GRAY_PACK_ROUND_EN
    logic       hb;
    logic [8:0] sum;
`endif
    s    = f[31];
    e    = f[30:23];
    m    = f[22:0];
    mant = {1'b1, m};
    sh   = 8'd150 - e;
    q    = 8'(mant >> sh);
    to_byte = 8'd0;
    if (e == 8'hFF && m != 23'd0)  to_byte = 8'd0;
    else if (s)                     to_byte = 8'd0;
    else if (e == 8'hFF)            to_byte = 8'hFF;
    else if (e >= 8'd135)           to_byte = 8'hFF;
`ifdef GRAY_PACK_ROUND_EN
    else if (e < 8'd126)            to_byte = 8'd0;
    else begin
      // Half bit sits just below the integer part; a carry out to 256 saturates.
      hb  = 1'(mant >> (sh - 8'd1));
      sum = {1'b0, q} + {8'd0, hb};
      to_byte = sum[8] ? 8'hFF : sum[7:0];
    end
`else
    else if (e < 8'd127)            to_byte = 8'd0;
    else                            to_byte = q;
`endif
  endfunction

  logic        c_valid_q, c_valid_d;
  logic [7:0]  c_byte_q, c_byte_d;
  logic [23:0] a_data_q, a_data_d;
  logic [1:0]  a_cnt_q, a_cnt_d;
  logic [19:0] pix_cnt_q, pix_cnt_d;
  logic        o_valid_q, o_valid_d;
  logic [31:0] o_data_q, o_data_d;
  logic [3:0]  o_keep_q, o_keep_d;
  logic        o_last_q, o_last_d;

  logic        c_last, o_free, completes, c_consume;
  logic [31:0] word;
  logic [3:0]  keep;

  always_comb begin
    c_last    = (pix_cnt_q == LAST_IDX);
    o_free    = !o_valid_q || out_ready;
    completes = c_valid_q && (a_cnt_q == 2'd3 || c_last);
    // A completing byte waits for O; any other byte always fits in A.
    c_consume = c_valid_q && (!completes || o_free);
    in_ready  = !c_valid_q || c_consume;

    case (a_cnt_q)
      2'd0:    begin word = {24'd0, c_byte_q};                  keep = 4'h1; end
      2'd1:    begin word = {16'd0, c_byte_q, a_data_q[7:0]};   keep = 4'h3; end
      2'd2:    begin word = {8'd0, c_byte_q, a_data_q[15:0]};   keep = 4'h7; end
      default: begin word = {c_byte_q, a_data_q};               keep = 4'hF; end
    endcase

    c_valid_d = c_valid_q;
    c_byte_d  = c_byte_q;
    a_data_d  = a_data_q;
    a_cnt_d   = a_cnt_q;
    pix_cnt_d = pix_cnt_q;
    o_valid_d = o_valid_q;
    o_data_d  = o_data_q;
    o_keep_d  = o_keep_q;
    o_last_d  = o_last_q;

    if (o_valid_q && out_ready) o_valid_d = 1'b0;

    if (c_consume) begin
      if (completes) begin
        o_valid_d = 1'b1;
        o_data_d  = word;
        o_keep_d  = keep;
        o_last_d  = c_last;
        a_data_d  = 24'd0;
        a_cnt_d   = 2'd0;
      end else begin
        a_data_d = a_data_q | (24'(c_byte_q) << {a_cnt_q, 3'b000});
        a_cnt_d  = a_cnt_q + 2'd1;
      end
      pix_cnt_d = c_last ? 20'd0 : pix_cnt_q + 20'd1;
      c_valid_d = 1'b0;
    end

    if (in_valid && in_ready) begin
      c_valid_d = 1'b1;
      c_byte_d  = to_byte(in_data);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_valid_q <= 1'b0;
      c_byte_q  <= 8'd0;
      a_data_q  <= 24'd0;
      a_cnt_q   <= 2'd0;
      pix_cnt_q <= 20'd0;
      o_valid_q <= 1'b0;
      o_data_q  <= 32'd0;
      o_keep_q  <= 4'd0;
      o_last_q  <= 1'b0;
    end else begin
      c_valid_q <= c_valid_d;
      c_byte_q  <= c_byte_d;
      a_data_q  <= a_data_d;
      a_cnt_q   <= a_cnt_d;
      pix_cnt_q <= pix_cnt_d;
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
      o_keep_q  <= o_keep_d;
      o_last_q  <= o_last_d;
    end
  end

  assign out_valid = o_valid_q;
  assign out_data  = o_data_q;
  assign out_keep  = o_keep_q;
  assign out_last  = o_last_q;

endmodule

// File: tb/tb_gray_pix_packer.sv
// Bench for gray_pix_packer: instance 0 uses the default frame size, instance 1 a 6-pixel frame.
// Expected words come from a real-arithmetic conversion model and a per-instance word queue.
module tb_gray_pix_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [31:0] in_data   [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [31:0] out_data  [2];
  logic [3:0]  out_keep  [2];
  logic        out_last  [2];

  gray_pix_packer dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .out_keep(out_keep[0]), .out_last(out_last[0])
  );

  gray_pix_packer #(.FRAME_PIXELS(6)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .out_keep(out_keep[1]), .out_last(out_last[1])
  );

  int checks = 0;
  int errors = 0;

  // Word image: {last, keep[3:0], data[31:0]}
  logic [36:0] exp_q0[$];
  logic [36:0] exp_q1[$];
  int          frame_sz [2] = '{10000, 6};
  logic [31:0] m_acc    [2];
  int          m_n      [2];
  int          m_pix    [2];
  int          words_seen [2];
  bit          rnd_rdy  [2];

  task automatic chk(input string tag, input logic [36:0] got, input logic [36:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_conv(input logic [31:0] f);
    int  e;
    real v;
    e = int'(f[30:23]);
    if (e == 255 && f[22:0] != 23'd0) return 8'd0;
    if (f[31]) return 8'd0;
    if (e == 255) return 8'd255;
    if (e == 0) return 8'd0;
    v = (1.0 + real'(f[22:0]) / 8388608.0) * (2.0 ** (e - 127));
`ifdef GRAY_PACK_ROUND_EN
    if (v >= 255.5) return 8'd255;
    return 8'(int'($floor(v + 0.5)));
`else
    if (v >= 255.0) return 8'd255;
    return 8'(int'($floor(v)));
`endif
  endfunction

  function automatic logic [31:0] rand_float();
    logic [31:0] specials [6] = '{32'h7FC00000, 32'h7F800000, 32'hFF800000,
                                  32'h80000000, 32'h00000001, 32'h437F8000};
    logic [31:0] m;
    logic [7:0]  e;
    if ($urandom_range(0, 9) == 0) return specials[$urandom_range(0, 5)];
    m = $urandom;
    if ($urandom_range(0, 3) == 0) m[15:0] = 16'd0;
    e = 8'($urandom_range(118, 137));
    return {($urandom_range(0, 7) == 0), e, m[22:0]};
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_acc[s] = 32'd0; m_n[s] = 0; m_pix[s] = 0;
    end
    exp_q0.delete();
    exp_q1.delete();
  endtask

  task automatic model_accept(input int s, input logic [31:0] d);
    logic        last;
    logic [36:0] w;
    m_acc[s] = m_acc[s] | (32'(ref_conv(d)) << (8 * m_n[s]));
    m_n[s]++;
    m_pix[s]++;
    last = (m_pix[s] == frame_sz[s]);
    if (m_n[s] == 4 || last) begin
      w = {last, 4'((1 << m_n[s]) - 1), m_acc[s]};
      if (s == 0) exp_q0.push_back(w); else exp_q1.push_back(w);
      m_acc[s] = 32'd0;
      m_n[s] = 0;
      if (last) m_pix[s] = 0;
    end
  endtask

  // Output monitor: a word transfers at the next rising edge when valid & ready hold now.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int s = 0; s < 2; s++) begin
        if (out_valid[s] && out_ready[s]) begin
          logic [36:0] got;
          int          qs;
          got = {out_last[s], out_keep[s], out_data[s]};
          qs  = (s == 0) ? exp_q0.size() : exp_q1.size();
          checks++;
          assert (qs != 0) else begin
            errors++;
            $error("FAIL unexpected_word%0d: observed=%h expected=none", s, got);
          end
          if (qs != 0) begin
            if (s == 0) chk("word0", got, exp_q0.pop_front());
            else        chk("word1", got, exp_q1.pop_front());
          end
          words_seen[s]++;
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the accepting edge.
  task automatic send(input int s, input logic [31:0] d);
    bit acc;
    int t;
    in_valid[s] = 1'b1;
    in_data[s]  = d;
    acc = 1'b0;
    t = 0;
    while (!acc && t < 100) begin
      if (rnd_rdy[s]) out_ready[s] = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = in_ready[s];
      @(posedge clk); #1;
      t++;
    end
    chk("send_accept", 37'(acc), 37'd1);
    if (acc) model_accept(s, d);
    in_valid[s] = 1'b0;
  endtask

  task automatic drain(input int s);
    int qs;
    out_ready[s] = 1'b1;
    rnd_rdy[s] = 1'b0;
    qs = (s == 0) ? exp_q0.size() : exp_q1.size();
    for (int t = 0; t < 200 && qs != 0; t++) begin
      @(posedge clk); #1;
      qs = (s == 0) ? exp_q0.size() : exp_q1.size();
    end
    chk("drain_empty", 37'(qs), 37'd0);
  endtask

  logic [31:0] bp_pix [16];
  int          bp_idx;
  int          ws_before;
  bit          acc;

  initial begin
    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      in_valid[s] = 1'b0; in_data[s] = 32'd0; out_ready[s] = 1'b1;
      rnd_rdy[s] = 1'b0; words_seen[s] = 0;
    end
    model_reset();
    #12;
    chk("rst_out_valid", 37'(out_valid[0]), 37'd0);
    chk("rst_out_word", {out_last[0], out_keep[0], out_data[0]}, 37'd0);
    chk("rst_in_ready", 37'(in_ready[0]), 37'd1);
    chk("rst_in_ready1", 37'(in_ready[1]), 37'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Pack order and 2-cycle latency
    send(0, 32'h42F60000); send(0, 32'h437F0000);
    send(0, 32'h00000000); send(0, 32'h3F800000);
    chk("pack_model", exp_q0[0], {1'b0, 4'hF, 32'h0100FF7B});
    @(negedge clk);
    chk("latency_t", 37'(out_valid[0]), 37'd0);
    @(negedge clk);
    chk("latency_t1", 37'(out_valid[0]), 37'd1);
    @(posedge clk); #1;
    drain(0);

    // Specials
    send(0, 32'hC2C80000); send(0, 32'h7FC00000);
    send(0, 32'h7F800000); send(0, 32'h43800000);
    chk("special_model", exp_q0[0], {1'b0, 4'hF, 32'hFFFF0000});
    drain(0);

    // Rounding boundaries
    send(0, 32'h42F70000); send(0, 32'h3F000000);
    send(0, 32'h437F6666); send(0, 32'h00000001);
    drain(0);

    // Backpressure: exactly 8 pixels fit with out_ready low
    for (int i = 0; i < 16; i++) bp_pix[i] = rand_float();
    ws_before = words_seen[0];
    out_ready[0] = 1'b0;
    bp_idx = 0;
    in_valid[0] = 1'b1;
    in_data[0] = bp_pix[0];
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      acc = in_ready[0];
      @(posedge clk); #1;
      if (acc) begin
        model_accept(0, bp_pix[bp_idx]);
        bp_idx++;
        in_data[0] = bp_pix[bp_idx];
      end
    end
    chk("bp_accepts", 37'(bp_idx), 37'd8);
    @(negedge clk);
    chk("bp_in_ready_low", 37'(in_ready[0]), 37'd0);
    @(posedge clk); #1;
    out_ready[0] = 1'b1;
    for (int i = bp_idx; i < 16; i++) send(0, bp_pix[i]);
    drain(0);
    chk("bp_words", 37'(words_seen[0] - ws_before), 37'd4);

    // Partial frames on the 6-pixel instance
    ws_before = words_seen[1];
    for (int i = 0; i < 12; i++) send(1, rand_float());
    drain(1);
    chk("frame_words", 37'(words_seen[1] - ws_before), 37'd4);

    // Random traffic with random backpressure
    rnd_rdy[1] = 1'b1;
    for (int i = 0; i < 60; i++) send(1, rand_float());
    drain(1);
    rnd_rdy[0] = 1'b1;
    for (int i = 0; i < 100; i++) send(0, rand_float());
    drain(0);

    // Asynchronous reset with O full and a partial word in flight
    out_ready[0] = 1'b0;
    for (int i = 0; i < 6; i++) send(0, rand_float());
    @(negedge clk);
    chk("pre_reset_valid", 37'(out_valid[0]), 37'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 37'(out_valid[0]), 37'd0);
    chk("mid_rst_out_word", {out_last[0], out_keep[0], out_data[0]}, 37'd0);
    chk("mid_rst_in_ready", 37'(in_ready[0]), 37'd1);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready[0] = 1'b1;
    ws_before = words_seen[0];
    for (int i = 0; i < 4; i++) send(0, rand_float());
    drain(0);
    chk("post_rst_words", 37'(words_seen[0] - ws_before), 37'd1);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
